latch_bank_arbiter: RTL and testbench

LATCH_BANK_ARBITER -- requirements
Module: latch_bank_arbiter

---
 rtl/latch_bank_arbiter_pkg.sv | 32 +++
 rtl/latch_bank_arbiter_if.sv | 26 ++
 rtl/latch_bank_arbiter_latch_word.sv | 17 +
 rtl/latch_bank_arbiter.sv | 99 +++++++++
 tb/tb_latch_bank_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/latch_bank_arbiter_pkg.sv
// Shared definitions for the two-requester latch-bank write arbiter:
// state encoding, default sizes and small helper functions.
package latch_arb_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH     = 4;
    localparam int AW        = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        ACK   = 3'd4
    } state_t;

    function automatic logic [DEPTH-1:0] onehot(input logic [AW-1:0] a);
        logic [DEPTH-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // On a tie the requester that was not granted last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/latch_bank_arbiter_if.sv
// Bundle of the requester, latch-bank and read-port signals of the arbiter.
interface latch_bank_arbiter_if #(
    parameter int WIDTH = latch_arb_pkg::WIDTH_DEF
);
    logic [1:0]                      req;
    logic [latch_arb_pkg::AW-1:0]    addr0;
    logic [latch_arb_pkg::AW-1:0]    addr1;
    logic [WIDTH-1:0]                wdata0;
    logic [WIDTH-1:0]                wdata1;
    logic [1:0]                      ack;
    logic                            busy;
    logic [latch_arb_pkg::DEPTH-1:0] lat_en;
    logic [WIDTH-1:0]                lat_d;
    logic [latch_arb_pkg::AW-1:0]    rd_addr;
    logic [WIDTH-1:0]                rd_data;

    modport master (
        output req, addr0, addr1, wdata0, wdata1, rd_addr,
        input  ack, busy, lat_en, lat_d, rd_data
    );

    modport slave (
        input  req, addr0, addr1, wdata0, wdata1, rd_addr,
        output ack, busy, lat_en, lat_d, rd_data
    );
endinterface

// File: rtl/latch_bank_arbiter_latch_word.sv
// One WIDTH-bit level-sensitive storage word: transparent while clk is high,
// holding otherwise. No reset value.
module latch_word #(
    parameter int WIDTH = latch_arb_pkg::WIDTH_DEF
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_latch begin
        if (clk) begin
            q <= d;
        end
    end

endmodule

// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter sequencing writes from two requesters into a bank of
// latches through a SETUP/PULSE/HOLD cycle, with a registered read port.
module latch_bank_arbiter
    import latch_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    latch_bank_arbiter_if.slave bus
);

    state_t           r_state;
    logic             r_owner;
    logic             r_last;
    logic [AW-1:0]    r_addr;
    logic [1:0]       r_ack;
    logic             r_busy;
    logic [DEPTH-1:0] r_lat_en;
    logic [WIDTH-1:0] r_lat_d;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_grant;
    logic [WIDTH-1:0] w_bank [DEPTH];

    assign w_grant = rr_pick(bus.req, r_last);

    // r_lat_d doubles as the captured write data; it stays stable until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ack    <= '0;
            r_lat_en <= '0;
            r_busy   <= 1'b0;
            r_lat_d  <= '0;
            r_last   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_owner <= w_grant;
                        r_last  <= w_grant;
                        r_addr  <= w_grant ? bus.addr1 : bus.addr0;
                        r_lat_d <= w_grant ? bus.wdata1 : bus.wdata0;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_lat_en <= onehot(r_addr);
                    r_state  <= PULSE;
                end
                PULSE: begin
                    r_lat_en <= '0;
                    r_state  <= HOLD;
                end
                HOLD: begin
                    r_ack   <= r_owner ? 2'b10 : 2'b01;
                    r_state <= ACK;
                end
                ACK: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack    <= '0;
                    r_lat_en <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_bank
        latch_word #(.WIDTH(WIDTH)) u_word (
            .clk (r_lat_en[i]),
            .d   (r_lat_d),
            .q   (w_bank[i])
        );
    end

    // The latch opens only after the edge ending SETUP, so reads return the new
    // value from the edge ending PULSE onward.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_bank[bus.rd_addr];
        end
    end

    assign bus.ack     = r_ack;
    assign bus.busy    = r_busy;
    assign bus.lat_en  = r_lat_en;
    assign bus.lat_d   = r_lat_d;
    assign bus.rd_data = r_rd_data;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed bench for latch_bank_arbiter: expected latch pulses and acks are
// queued at issue time and checked by an independent monitor.
module tb_latch_bank_arbiter;

    localparam int W = 4;

    typedef struct {
        int         cyc;
        logic [1:0] ack;
    } ack_t;

    typedef struct {
        int         cyc;
        logic [3:0] en;
        logic [W-1:0] d;
    } lat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   c;
    ack_t ack_q[$];
    lat_t lat_q[$];
    ack_t ea;
    lat_t el;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    latch_bank_arbiter_if #(.WIDTH(W)) bus ();

    latch_bank_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_lat(input int at, input logic [3:0] en, input logic [W-1:0] d);
        lat_t e;
        e.cyc = at;
        e.en  = en;
        e.d   = d;
        lat_q.push_back(e);
    endtask

    task automatic push_ack(input int at, input logic [1:0] a);
        ack_t e;
        e.cyc = at;
        e.ack = a;
        ack_q.push_back(e);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [W-1:0] v, input string name);
        bus.rd_addr = a;
        tick(1);
        chk(name, bus.rd_data, v);
    endtask

    // Monitor: every latch pulse and every ack must match the next queued expectation.
    always @(negedge clk) begin
        if ((|bus.lat_en) === 1'b1) begin
            n_vec++;
            if (lat_q.size() == 0) begin
                n_bad++;
                $display("FAIL lat_en_unexpected: got %b, required none (cycle %0d)", bus.lat_en, cyc);
            end else begin
                el = lat_q.pop_front();
                if (bus.lat_en !== el.en || bus.lat_d !== el.d || cyc != el.cyc) begin
                    n_bad++;
                    $display("FAIL lat_pulse: got en=%b d=%h cyc=%0d, required en=%b d=%h cyc=%0d",
                             bus.lat_en, bus.lat_d, cyc, el.en, el.d, el.cyc);
                end
            end
        end
        if ((|bus.ack) === 1'b1) begin
            n_vec++;
            if (ack_q.size() == 0) begin
                n_bad++;
                $display("FAIL ack_unexpected: got %b, required none (cycle %0d)", bus.ack, cyc);
            end else begin
                ea = ack_q.pop_front();
                if (bus.ack !== ea.ack || cyc != ea.cyc) begin
                    n_bad++;
                    $display("FAIL ack_pulse: got ack=%b cyc=%0d, required ack=%b cyc=%0d",
                             bus.ack, cyc, ea.ack, ea.cyc);
                end
            end
        end
    end

    initial begin
        bus.req     = 2'b00;
        bus.addr0   = 2'd0;
        bus.addr1   = 2'd0;
        bus.wdata0  = '0;
        bus.wdata1  = '0;
        bus.rd_addr = 2'd0;
        rst = 1'b1;
        tick(2);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_ack", bus.ack, 2'b00);
        chk("reset_lat_en", bus.lat_en, 4'b0000);
        chk("reset_lat_d", bus.lat_d, 4'h0);
        chk("reset_rd_data", bus.rd_data, 4'h0);
        rst = 1'b0;

        // Single write of 0xA to word 2 by requester 0
        c = cyc;
        bus.req = 2'b01; bus.addr0 = 2'd2; bus.wdata0 = 4'hA;
        push_lat(c + 2, 4'b0100, 4'hA);
        push_ack(c + 4, 2'b01);
        tick(1);
        chk("busy_setup", bus.busy, 1'b1);
        tick(3);
        bus.req = 2'b00;
        tick(1);
        chk("busy_idle_after_ack", bus.busy, 1'b0);
        rd_chk(2'd2, 4'hA, "read_w2_A");

        // Tie after reset: 0 first, then 1, then a second tie goes to 0 again
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        c = cyc;
        bus.req = 2'b11;
        bus.addr0 = 2'd0; bus.wdata0 = 4'h1;
        bus.addr1 = 2'd1; bus.wdata1 = 4'h2;
        push_lat(c + 2, 4'b0001, 4'h1);
        push_ack(c + 4, 2'b01);
        push_lat(c + 7, 4'b0010, 4'h2);
        push_ack(c + 9, 2'b10);
        tick(4);
        bus.req = 2'b10;
        tick(5);
        bus.req = 2'b00;
        tick(1);
        c = cyc;
        bus.req = 2'b11;
        bus.addr0 = 2'd3; bus.wdata0 = 4'h3;
        bus.addr1 = 2'd0; bus.wdata1 = 4'h4;
        push_lat(c + 2, 4'b1000, 4'h3);
        push_ack(c + 4, 2'b01);
        push_lat(c + 7, 4'b0001, 4'h4);
        push_ack(c + 9, 2'b10);
        tick(4);
        bus.req = 2'b10;
        tick(5);
        bus.req = 2'b00;
        tick(1);
        rd_chk(2'd0, 4'h4, "read_w0_4");
        rd_chk(2'd3, 4'h3, "read_w3_3");
        rd_chk(2'd1, 4'h2, "read_w1_2");

        // addr/wdata changed in SETUP must be ignored
        c = cyc;
        bus.req = 2'b01; bus.addr0 = 2'd1; bus.wdata0 = 4'h5;
        push_lat(c + 2, 4'b0010, 4'h5);
        push_ack(c + 4, 2'b01);
        tick(1);
        bus.wdata0 = 4'hF; bus.addr0 = 2'd3;
        tick(3);
        bus.req = 2'b00;
        tick(1);
        rd_chk(2'd1, 4'h5, "read_w1_5");
        rd_chk(2'd3, 4'h3, "read_w3_untouched");

        // Read-during-write: 0xC then 0x3 into word 3
        c = cyc;
        bus.req = 2'b01; bus.addr0 = 2'd3; bus.wdata0 = 4'hC;
        push_lat(c + 2, 4'b1000, 4'hC);
        push_ack(c + 4, 2'b01);
        tick(4);
        bus.req = 2'b00;
        tick(1);
        c = cyc;
        bus.rd_addr = 2'd3;
        bus.req = 2'b01; bus.addr0 = 2'd3; bus.wdata0 = 4'h3;
        push_lat(c + 2, 4'b1000, 4'h3);
        push_ack(c + 4, 2'b01);
        tick(1);
        chk("rdw_setup_old", bus.rd_data, 4'hC);
        tick(1);
        chk("rdw_pulse_old", bus.rd_data, 4'hC);
        tick(1);
        chk("rdw_after_pulse_new", bus.rd_data, 4'h3);
        tick(1);
        bus.req = 2'b00;
        tick(1);

        // Reset during HOLD aborts the transaction without an ack
        c = cyc;
        bus.req = 2'b01; bus.addr0 = 2'd0; bus.wdata0 = 4'h9;
        push_lat(c + 2, 4'b0001, 4'h9);
        tick(3);
        rst = 1'b1;
        bus.req = 2'b00;
        tick(1);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_ack", bus.ack, 2'b00);
        chk("abort_lat_en", bus.lat_en, 4'b0000);
        chk("abort_lat_d", bus.lat_d, 4'h0);
        chk("abort_rd_data", bus.rd_data, 4'h0);
        rst = 1'b0;
        tick(2);
        rd_chk(2'd1, 4'h5, "abort_keep_w1");
        rd_chk(2'd3, 4'h3, "abort_keep_w3");
        rd_chk(2'd2, 4'hA, "abort_keep_w2");

        // req dropped in PULSE: ack still pulses, no re-grant
        c = cyc;
        bus.req = 2'b01; bus.addr0 = 2'd2; bus.wdata0 = 4'h6;
        push_lat(c + 2, 4'b0100, 4'h6);
        push_ack(c + 4, 2'b01);
        tick(2);
        bus.req = 2'b00;
        tick(3);
        chk("drop_idle_busy", bus.busy, 1'b0);
        tick(1);
        chk("drop_no_regrant", bus.busy, 1'b0);
        rd_chk(2'd2, 4'h6, "read_w2_6");

        tick(3);
        chk("lat_queue_drained", lat_q.size(), 0);
        chk("ack_queue_drained", ack_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
